// File: rtl/rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_scheduler
// Brief    : Work-conserving round-robin scheduler for one shared vector lane,
//            with multi-cycle ownership, done handshake and hold-time preemption.
// Revision : 1.0  initial release
// ============================================================================
module rr_grant_scheduler #(
    parameter int NUM_REQ  = 8,
    parameter int MAX_HOLD = 16,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic               preempt
);

    localparam int                C_HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(MAX_HOLD - 1);
    localparam logic [0:0]        C_ST_IDLE   = 1'b0;
    localparam logic [0:0]        C_ST_OWNED  = 1'b1;

    logic [0:0]          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [C_HOLD_W-1:0] r_hold_cnt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [ID_W-1:0]     r_gnt_id;
    logic                r_preempt;

    logic [NUM_REQ-1:0]  w_ptr_oh;
    logic [NUM_REQ-1:0]  w_prefix;
    logic [NUM_REQ-1:0]  w_mask;
    logic [NUM_REQ-1:0]  w_others;
    logic [NUM_REQ-1:0]  w_cand;
    logic [NUM_REQ-1:0]  w_masked;
    logic [NUM_REQ-1:0]  w_pick;
    logic [NUM_REQ-1:0]  w_win_oh;
    logic [ID_W-1:0]     w_win_id;
    logic                w_any;
    logic                w_owned;
    logic                w_done_rel;
    logic                w_abandon;
    logic                w_preempt;
    logic                w_release;

    always_comb begin
        // Thermometer mask of positions strictly above ptr, via log-step prefix OR
        w_ptr_oh = NUM_REQ'(1) << r_ptr;
        w_prefix = w_ptr_oh;
        for (int s = 1; s < NUM_REQ; s = s * 2) begin
            w_prefix = w_prefix | (w_prefix << s);
        end
        w_mask = w_prefix << 1;

        w_owned    = (r_state == C_ST_OWNED);
        w_others   = req & ~r_gnt;
        w_done_rel = w_owned && done;
        w_abandon  = w_owned && !done && !(|(req & r_gnt));
        w_preempt  = w_owned && !done && !w_abandon &&
                     (r_hold_cnt == C_HOLD_LAST) && (|w_others);
        w_release  = w_done_rel || w_abandon || w_preempt;

        // After done the owner may compete again; ptr==owner gives it lowest priority
        w_cand   = (!w_owned || done) ? req : w_others;
        w_masked = w_cand & w_mask;
        w_pick   = (|w_masked) ? w_masked : w_cand;
        w_win_oh = w_pick & (~w_pick + NUM_REQ'(1));
        w_any    = |w_cand;

        w_win_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_oh[i]) begin
                w_win_id = w_win_id | ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= C_ST_IDLE;
            r_ptr      <= ID_W'(NUM_REQ - 1);
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_preempt  <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    r_preempt <= 1'b0;
                    if (w_any) begin
                        r_state    <= C_ST_OWNED;
                        r_gnt      <= w_win_oh;
                        r_gnt_id   <= w_win_id;
                        r_ptr      <= w_win_id;
                        r_hold_cnt <= '0;
                    end
                end
                default: begin
                    if (w_release) begin
                        if (w_any) begin
                            r_gnt      <= w_win_oh;
                            r_gnt_id   <= w_win_id;
                            r_ptr      <= w_win_id;
                            r_hold_cnt <= '0;
                            r_preempt  <= w_preempt;
                        end else begin
                            r_state    <= C_ST_IDLE;
                            r_gnt      <= '0;
                            r_gnt_id   <= '0;
                            r_hold_cnt <= '0;
                            r_preempt  <= 1'b0;
                        end
                    end else begin
                        r_preempt <= 1'b0;
                        if (r_hold_cnt != C_HOLD_LAST) begin
                            r_hold_cnt <= r_hold_cnt + C_HOLD_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = |r_gnt;
    assign gnt_id    = r_gnt_id;
    assign preempt   = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_grant_scheduler
// Brief    : Directed-vector bench for rr_grant_scheduler (NUM_REQ=8, MAX_HOLD=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_grant_scheduler;

    localparam int NUM_REQ  = 8;
    localparam int MAX_HOLD = 4;
    localparam int ID_W     = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [ID_W-1:0]    gnt_id;
    logic               preempt;

    int n_vec = 0;
    int n_err = 0;

    rr_grant_scheduler #(
        .NUM_REQ  (NUM_REQ),
        .MAX_HOLD (MAX_HOLD),
        .ID_W     (ID_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_gnt,
                             input logic [2:0] exp_id, input logic exp_pre);
        check({tag, ".gnt"},       32'(gnt),       32'(exp_gnt));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(exp_gnt != 8'h00));
        check({tag, ".gnt_id"},    32'(gnt_id),    32'(exp_id));
        check({tag, ".preempt"},   32'(preempt),   32'(exp_pre));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        done  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] seq1 [5];
        logic [2:0] id1  [5];
        seq1 = '{8'h01, 8'h04, 8'h01, 8'h04, 8'h01};
        id1  = '{3'd0,  3'd2,  3'd0,  3'd2,  3'd0};

        reset = 1'b1;
        req   = '0;
        done  = 1'b0;
        tick();
        check_out("reset", 8'h00, 3'd0, 1'b0);
        reset = 1'b0;

        // 1: two requesters alternate, done on every second grant cycle
        req = 8'h05;
        tick();
        check_out("t1.first", seq1[0], id1[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            done = 1'b0;
            tick();
            check_out($sformatf("t1.hold%0d", k), seq1[k], id1[k], 1'b0);
            done = 1'b1;
            tick();
            check_out($sformatf("t1.next%0d", k), seq1[k+1], id1[k+1], 1'b0);
        end
        req  = '0;
        done = 1'b0;
        tick();
        check_out("t1.idle", 8'h00, 3'd0, 1'b0);

        // 2: all requesting with done every cycle walks 0..7 then wraps
        do_reset();
        req  = 8'hFF;
        done = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_out($sformatf("t2.rr%0d", k), 8'(1 << (k % 8)), 3'(k % 8), 1'b0);
        end

        // 3: sole requester is never preempted; a newcomer forces preemption
        do_reset();
        req = 8'h08;
        tick();
        check_out("t3.grant", 8'h08, 3'd3, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_out($sformatf("t3.sole%0d", k), 8'h08, 3'd3, 1'b0);
        end
        req = 8'h28;
        tick();
        check_out("t3.preempt", 8'h20, 3'd5, 1'b1);
        tick();
        check_out("t3.after", 8'h20, 3'd5, 1'b0);

        // 4: owner abandons with no other request, then re-requests
        do_reset();
        req = 8'h04;
        tick();
        check_out("t4.grant", 8'h04, 3'd2, 1'b0);
        req = 8'h00;
        tick();
        check_out("t4.drop", 8'h00, 3'd0, 1'b0);
        tick();
        check_out("t4.idle", 8'h00, 3'd0, 1'b0);
        req = 8'h04;
        tick();
        check_out("t4.regrant", 8'h04, 3'd2, 1'b0);

        // 5: reset during ownership, first grant afterwards is requester 0
        do_reset();
        req = 8'h40;
        tick();
        check_out("t5.own6", 8'h40, 3'd6, 1'b0);
        req = 8'hFF;
        tick();
        check_out("t5.held", 8'h40, 3'd6, 1'b0);
        reset = 1'b1;
        tick();
        check_out("t5.reset", 8'h00, 3'd0, 1'b0);
        reset = 1'b0;
        tick();
        check_out("t5.first", 8'h01, 3'd0, 1'b0);

        // 6: done with owner still requesting hands off; owner regains as sole requester
        do_reset();
        req = 8'h02;
        tick();
        check_out("t6.own1", 8'h02, 3'd1, 1'b0);
        req  = 8'h12;
        done = 1'b1;
        tick();
        check_out("t6.to4", 8'h10, 3'd4, 1'b0);
        req = 8'h02;
        tick();
        check_out("t6.to1", 8'h02, 3'd1, 1'b0);
        done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Work-conserving round-robin arbiter/scheduler that shares one vector-lane resource among NUM_REQ requesters.
- Issues a registered one-hot grant and holds it for the owner's transaction, with multi-cycle ownership, completion handshake, and forced preemption after MAX_HOLD cycles.
- Priority rotation uses a thermometer mask over the request vector, computed with parallel-prefix OR.
- Sits between the vector lane requesters and the shared execution/memory port.

Parameters:
NUM_REQ, 8, number of requesters (>=2).
MAX_HOLD, 16, maximum ownership cycles before preemption when others are waiting (>=1).
ID_W, $clog2(NUM_REQ), width of grant index.

Ports:
clk  input  1  clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
req  input  NUM_REQ  level request per requester; held high until served.
done  input  1  owner signals last cycle of its transaction; ignored when no owner.
gnt  output  NUM_REQ  registered one-hot grant, zero when idle.
gnt_valid  output  1  high while any grant is asserted (== |gnt).
gnt_id  output  ID_W  binary index of granted requester; 0 when idle.
preempt  output  1  one-cycle pulse, coincident with the first cycle of a grant produced by preemption.

Behaviour:
- Reset, synchronous, active-high: gnt=0, gnt_valid=0, gnt_id=0, preempt=0, state=IDLE, ptr=NUM_REQ-1, hold_cnt=0.
  - Reset during ownership clears the grant at that edge. The next arbitration starts with requester 0 highest.
- Arbitration function (combinational), input vector v:
  - mask[i]=1 for i>ptr (prefix OR of one-hot(ptr), shifted by one). mv = v & mask.
  - Winner = lowest set bit of mv if mv!=0, else lowest set bit of v.
- States: IDLE, OWNED.
- IDLE:
  - If req!=0, winner = arb(req). At the next edge: gnt=onehot(winner), gnt_id=winner, ptr=winner, hold_cnt=0, state=OWNED.
  - Latency: request sampled at edge k gives grant visible after edge k (1 cycle). No grant if req==0.
- OWNED, evaluated each cycle with owner o:
  - Release if done=1, OR req[o]=0 (abandon), OR (hold_cnt==MAX_HOLD-1 AND (req & ~onehot(o))!=0) (preempt).
  - On release: winner = arb(req with bit o cleared if abandon or preempt; bit o kept if done).
    - If a winner exists, grant it at the next edge with no idle bubble. hold_cnt=0, ptr=winner, state stays OWNED.
    - Else gnt=0 and state=IDLE.
  - Since ptr==o, the re-requesting owner after done has lowest priority. It is re-granted only if it is the sole requester.
  - No release: grant held. hold_cnt increments, saturating at MAX_HOLD-1.
  - Work-conserving: a sole requester is never preempted, and keeps its grant with hold_cnt saturated.
- Precedence within one cycle: done > abandon > preempt. preempt pulses only when preemption is the release cause and done=0.
- gnt is always one-hot or zero, never multi-hot. gnt_id and gnt_valid stay consistent with gnt every cycle.
- Pointer wrap: ptr=NUM_REQ-1 gives an all-zero mask, so the winner is the lowest set bit (wrap to requester 0 side).
- Changes to req while a grant is held do not alter gnt until a release condition occurs.

Test Plan:
1. NUM_REQ=8, req=8'b0000_0101 constant, done pulsed on every second grant cycle -> gnt sequence 0x01,0x04,0x01,0x04. Each grant lasts 2 cycles, no idle gaps.
2. req=8'hFF, done=1 every cycle -> gnt_id 0,1,2,...,7,0 on consecutive cycles (wrap-around). gnt_valid stays 1.
3. MAX_HOLD=4, only req[3] high, done=0 for 10 cycles -> gnt=0x08 held throughout, preempt never asserts. Then assert req[5] -> once hold_cnt has reached 3, the next edge gives gnt=0x20 with preempt=1 for one cycle.
4. Owner 2 drops req[2] without done, other req=0 -> gnt=0 and gnt_valid=0 one cycle later, state IDLE. A later req[2] is re-granted after 1 cycle.
5. Owner 6 mid-transaction, reset asserted one cycle with req=8'hFF -> gnt=0 after reset edge. The first post-reset grant is gnt_id=0, not 7.
6. Owner 1, done=1 and req[1] still high with req[4] high -> next grant is 4. After done on 4 with only req[1] high -> grant 1.
